// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC owner and instruction fetch front end for the multicycle core.
// Ports: clk, rst_n (sync, active-low); fetch_en, pc_write, pc_src, branch_target
//        from control/datapath; imem_req/imem_addr/imem_ack/imem_rdata memory
//        handshake; pc, pc_plus4, instr, opcode, instr_valid, busy, fetch_err,
//        misalign_err status and results.
module instr_fetch_unit #(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_PC    = '0,
    parameter int              TIMEOUT_CYC = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            fetch_en,
    input  logic            pc_write,
    input  logic            pc_src,
    input  logic [XLEN-1:0] branch_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic [31:0]     instr,
    output logic [6:0]      opcode,
    output logic            instr_valid,
    output logic            busy,
    output logic            fetch_err,
    output logic            misalign_err
);

    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);
    localparam logic [31:0]   NOP      = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, REQ, HOLD, ERR} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic            req_q, req_d;
    logic [31:0]     instr_q, instr_d;
    logic            valid_q, valid_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ferr_q, ferr_d;
    logic            merr_q, merr_d;

    logic [XLEN-1:0] next_pc;
    logic            can_issue;
    logic            pc_wr_ok;
    logic            bad_tgt;
    logic            pc_upd;

    assign pc_plus4  = pc_q + XLEN'(4);
    assign next_pc   = pc_src ? branch_target : pc_plus4;
    assign can_issue = (state_q == IDLE) || (state_q == HOLD);
    assign pc_wr_ok  = pc_write && can_issue;
    // A misaligned branch target is refused: PC stays put, error latches.
    assign bad_tgt   = pc_src && (branch_target[1:0] != 2'b00);
    assign pc_upd    = pc_wr_ok && !bad_tgt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            req_q   <= 1'b0;
            instr_q <= NOP;
            valid_q <= 1'b0;
            cnt_q   <= '0;
            ferr_q  <= 1'b0;
            merr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            req_q   <= req_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            ferr_q  <= ferr_d;
            merr_q  <= merr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        req_d   = req_q;
        instr_d = instr_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        ferr_d  = ferr_q;
        merr_d  = merr_q;

        if (pc_wr_ok) begin
            if (bad_tgt) merr_d = 1'b1;
            else         pc_d   = next_pc;
        end

        unique case (state_q)
            IDLE, HOLD: begin
                if (fetch_en) begin
                    state_d = REQ;
                    // A same-cycle PC update wins: fetch from the new PC.
                    addr_d  = pc_upd ? next_pc : pc_q;
                    req_d   = 1'b1;
                    valid_d = 1'b0;
                    cnt_d   = '0;
                end
            end
            REQ: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    req_d   = 1'b0;
                    valid_d = 1'b1;
                    state_d = HOLD;
                end else if (cnt_q == CNT_LAST) begin
                    req_d   = 1'b0;
                    ferr_d  = 1'b1;
                    state_d = ERR;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ERR: begin
                req_d   = 1'b0;
                valid_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    assign pc           = pc_q;
    assign imem_req     = req_q;
    assign imem_addr    = addr_q;
    assign instr        = instr_q;
    assign opcode       = instr_q[6:0];
    assign instr_valid  = valid_q;
    assign busy         = (state_q == REQ);
    assign fetch_err    = ferr_q;
    assign misalign_err = merr_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed and randomized checks of instr_fetch_unit
// against a small PC/instruction model kept in the bench.
module tb_instr_fetch_unit;

    localparam int TO = 16;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_en = 1'b0;
    logic        pc_write = 1'b0;
    logic        pc_src = 1'b0;
    logic [31:0] branch_target = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic        instr_valid;
    logic        busy;
    logic        fetch_err;
    logic        misalign_err;

    int checks = 0;
    int failures = 0;

    logic [31:0] f_addr;
    int          f_req;
    bit          f_stable;
    bit          f_vlow;

    instr_fetch_unit #(
        .XLEN(32), .RESET_PC(32'h0), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .fetch_en(fetch_en), .pc_write(pc_write),
        .pc_src(pc_src), .branch_target(branch_target),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .pc(pc), .pc_plus4(pc_plus4),
        .instr(instr), .opcode(opcode),
        .instr_valid(instr_valid), .busy(busy),
        .fetch_err(fetch_err), .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        fetch_en = 1'b0;
        pc_write = 1'b0;
        imem_ack = 1'b0;
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic pc_wr(input bit src, input logic [31:0] tgt);
        pc_write = 1'b1;
        pc_src = src;
        branch_target = tgt;
        cyc();
        pc_write = 1'b0;
    endtask

    // Drives one fetch (optionally with a same-cycle pc_write), acks after
    // 'waits' wait states, and records what was seen while the request was open.
    task automatic run_fetch(
        input  logic [31:0] data,
        input  int          waits,
        input  bit          pw,
        input  bit          src,
        input  logic [31:0] tgt,
        input  bit          noise,
        output logic [31:0] addr,
        output int          req_cyc,
        output bit          stable,
        output bit          vlow
    );
        fetch_en = 1'b1;
        pc_write = pw;
        pc_src = src;
        branch_target = tgt;
        cyc();
        fetch_en = 1'b0;
        pc_write = 1'b0;
        addr = imem_addr;
        req_cyc = 0;
        stable = 1'b1;
        vlow = 1'b1;
        for (int i = 0; i <= waits; i++) begin
            if (imem_req === 1'b1) req_cyc++;
            if (imem_addr !== addr) stable = 1'b0;
            if (instr_valid !== 1'b0) vlow = 1'b0;
            if (noise) begin
                fetch_en = 1'($urandom);
                pc_write = 1'($urandom);
                pc_src = 1'($urandom);
                branch_target = $urandom;
            end
            imem_ack = (i == waits);
            imem_rdata = (i == waits) ? data : $urandom;
            cyc();
        end
        imem_ack = 1'b0;
        fetch_en = 1'b0;
        pc_write = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (pc !== 32'h0) begin
            failures++;
            $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0);
        end
        checks++;
        if (instr !== NOP || opcode !== 7'h13) begin
            failures++;
            $display("FAIL reset_instr got=%h exp=%h", instr, NOP);
        end
        checks++;
        if ({imem_req, instr_valid, busy, fetch_err, misalign_err} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=00000",
                {imem_req, instr_valid, busy, fetch_err, misalign_err});
        end
        checks++;
        if (imem_addr !== 32'h0) begin
            failures++;
            $display("FAIL reset_addr got=%h exp=%h", imem_addr, 32'h0);
        end
    endtask

    task automatic test_zero_wait();
        run_fetch(32'h00B50533, 0, 0, 0, 0, 0, f_addr, f_req, f_stable, f_vlow);
        checks++;
        if (f_addr !== 32'h0 || f_req != 1 || !f_vlow) begin
            failures++;
            $display("FAIL zw_req got addr=%h req=%0d vlow=%0d exp addr=0 req=1 vlow=1",
                f_addr, f_req, f_vlow);
        end
        checks++;
        if (instr_valid !== 1'b1 || instr !== 32'h00B50533) begin
            failures++;
            $display("FAIL zw_instr got v=%b instr=%h exp v=1 instr=00b50533",
                instr_valid, instr);
        end
        checks++;
        if (opcode !== 7'b0110011 || pc !== 32'h0 || imem_req !== 1'b0) begin
            failures++;
            $display("FAIL zw_state got op=%b pc=%h req=%b exp op=0110011 pc=0 req=0",
                opcode, pc, imem_req);
        end
    endtask

    task automatic test_wait_states();
        for (int i = 0; i < 3; i++) pc_wr(1'b0, 32'h0);
        checks++;
        if (pc !== 32'd12 || instr_valid !== 1'b1) begin
            failures++;
            $display("FAIL ws_pc got pc=%h v=%b exp pc=0000000c v=1", pc, instr_valid);
        end
        run_fetch(32'h00050583, 3, 0, 0, 0, 0, f_addr, f_req, f_stable, f_vlow);
        checks++;
        if (f_addr !== 32'd12 || f_req != 4 || !f_stable || !f_vlow) begin
            failures++;
            $display("FAIL ws_req got addr=%h req=%0d st=%0d vlow=%0d exp 0000000c 4 1 1",
                f_addr, f_req, f_stable, f_vlow);
        end
        checks++;
        if (instr_valid !== 1'b1 || opcode !== 7'b0000011) begin
            failures++;
            $display("FAIL ws_instr got v=%b op=%b exp v=1 op=0000011",
                instr_valid, opcode);
        end
    endtask

    task automatic test_same_cycle();
        do_reset();
        pc_wr(1'b0, 32'h0);
        pc_wr(1'b0, 32'h0);
        run_fetch(32'h00000063, 1, 1, 1, 32'h40, 0, f_addr, f_req, f_stable, f_vlow);
        checks++;
        if (f_addr !== 32'h40 || pc !== 32'h40) begin
            failures++;
            $display("FAIL same_cyc got addr=%h pc=%h exp addr=00000040 pc=00000040",
                f_addr, pc);
        end
    endtask

    task automatic test_misalign();
        pc_wr(1'b1, 32'h42);
        checks++;
        if (pc !== 32'h40 || misalign_err !== 1'b1) begin
            failures++;
            $display("FAIL misalign got pc=%h err=%b exp pc=00000040 err=1",
                pc, misalign_err);
        end
        for (int i = 0; i < 2; i++) begin
            run_fetch($urandom, i, 0, 0, 0, 0, f_addr, f_req, f_stable, f_vlow);
            checks++;
            if (misalign_err !== 1'b1 || f_addr !== 32'h40) begin
                failures++;
                $display("FAIL misalign_sticky got err=%b addr=%h exp err=1 addr=00000040",
                    misalign_err, f_addr);
            end
        end
    endtask

    task automatic test_timeout();
        logic [31:0] pc_save;
        int req_cnt;
        pc_save = pc;
        fetch_en = 1'b1;
        cyc();
        fetch_en = 1'b0;
        req_cnt = 0;
        for (int i = 0; i < TO + 4; i++) begin
            if (imem_req === 1'b1) req_cnt++;
            cyc();
        end
        checks++;
        if (req_cnt != TO || imem_req !== 1'b0) begin
            failures++;
            $display("FAIL timeout_req got cycles=%0d req=%b exp cycles=%0d req=0",
                req_cnt, imem_req, TO);
        end
        checks++;
        if (fetch_err !== 1'b1 || busy !== 1'b0 || instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL timeout_err got err=%b busy=%b v=%b exp 1 0 0",
                fetch_err, busy, instr_valid);
        end
        fetch_en = 1'b1;
        pc_write = 1'b1;
        pc_src = 1'b0;
        imem_ack = 1'b1;
        cyc();
        cyc();
        fetch_en = 1'b0;
        pc_write = 1'b0;
        imem_ack = 1'b0;
        checks++;
        if (imem_req !== 1'b0 || pc !== pc_save || instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL err_terminal got req=%b pc=%h v=%b exp req=0 pc=%h v=0",
                imem_req, pc, instr_valid, pc_save);
        end
        do_reset();
        checks++;
        if ({fetch_err, misalign_err, imem_req, busy} !== 4'b0 || pc !== 32'h0
            || instr !== NOP || imem_addr !== 32'h0) begin
            failures++;
            $display("FAIL err_reset got fe=%b me=%b pc=%h instr=%h exp 0 0 0 %h",
                fetch_err, misalign_err, pc, instr, NOP);
        end
    endtask

    task automatic test_reset_mid();
        pc_wr(1'b0, 32'h0);
        fetch_en = 1'b1;
        cyc();
        fetch_en = 1'b0;
        checks++;
        if (busy !== 1'b1 || imem_addr !== 32'h4) begin
            failures++;
            $display("FAIL mid_busy got busy=%b addr=%h exp busy=1 addr=00000004",
                busy, imem_addr);
        end
        rst_n = 1'b0;
        imem_ack = 1'b1;
        imem_rdata = 32'hDEADBEEF;
        cyc();
        rst_n = 1'b1;
        cyc();
        imem_ack = 1'b0;
        checks++;
        if (instr !== NOP || instr_valid !== 1'b0 || pc !== 32'h0
            || imem_req !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset got instr=%h v=%b pc=%h req=%b exp %h 0 0 0",
                instr, instr_valid, pc, imem_req, NOP);
        end
        pc_wr(1'b1, 32'hFFFF_FFFC);
        checks++;
        if (pc !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0) begin
            failures++;
            $display("FAIL wrap got pc=%h pc4=%h exp fffffffc 00000000", pc, pc_plus4);
        end
        pc_wr(1'b0, 32'h0);
        checks++;
        if (pc !== 32'h0) begin
            failures++;
            $display("FAIL wrap_step got pc=%h exp 00000000", pc);
        end
    endtask

    task automatic test_random();
        logic [31:0] m_pc;
        logic [31:0] m_instr;
        bit          m_valid;
        bit          m_merr;
        do_reset();
        m_pc = 32'h0;
        m_instr = NOP;
        m_valid = 1'b0;
        m_merr = 1'b0;
        for (int n = 0; n < 40; n++) begin
            int          op;
            bit          src;
            logic [31:0] tgt;
            logic [31:0] data;
            int          waits;
            op = $urandom_range(0, 2);
            src = 1'($urandom);
            tgt = $urandom;
            if ($urandom_range(0, 2) != 0) tgt[1:0] = 2'b00;
            if (op != 2) begin
                if (src && tgt[1:0] != 2'b00) m_merr = 1'b1;
                else m_pc = src ? tgt : m_pc + 32'd4;
            end
            if (op == 0) begin
                pc_wr(src, tgt);
            end else begin
                data = $urandom;
                waits = $urandom_range(0, 5);
                run_fetch(data, waits, op == 1, src, tgt, 1,
                    f_addr, f_req, f_stable, f_vlow);
                m_instr = data;
                m_valid = 1'b1;
                checks++;
                if (f_addr !== m_pc || f_req != waits + 1 || !f_stable || !f_vlow) begin
                    failures++;
                    $display("FAIL rnd_fetch n=%0d got addr=%h req=%0d exp addr=%h req=%0d",
                        n, f_addr, f_req, m_pc, waits + 1);
                end
            end
            checks++;
            if (pc !== m_pc || instr !== m_instr || instr_valid !== m_valid
                || misalign_err !== m_merr || pc_plus4 !== m_pc + 32'd4) begin
                failures++;
                $display("FAIL rnd_state n=%0d got pc=%h i=%h v=%b me=%b exp %h %h %b %b",
                    n, pc, instr, instr_valid, misalign_err,
                    m_pc, m_instr, m_valid, m_merr);
            end
        end
    endtask

    initial begin
        cyc();
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_same_cycle();
        test_misalign();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
